// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and types shared by the NTT arithmetic blocks
// (operand multiplier and Barrett reducer).
//   NTT_OPERAND_W  - default coefficient / twiddle width
//   NTT_PRIME      - default NTT modulus
//   NTT_PRODUCT_W  - double-width product, equal to the reducer's data_size
//   mult_state_t   - operand multiplier FSM states
package ntt_pkg;

    localparam int unsigned NTT_OPERAND_W = 7;
    localparam int unsigned NTT_PRIME     = 101;

    // A full product of two w-bit operands needs 2*w bits.
    function automatic int unsigned ntt_product_w(input int unsigned w);
        return 2 * w;
    endfunction

    localparam int unsigned NTT_PRODUCT_W = ntt_product_w(NTT_OPERAND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : ntt_pkg

// File: rtl/mod_operand_multiplier.sv
// mod_operand_multiplier: iterative shift-add multiplier producing the
// double-width product consumed by the Barrett reduction stage.
// One operation in flight; fixed latency of OPERAND_W MUL cycles.
//
// Optional feature macro: MULT_OPERAND_CHECK_EN
//   When defined, operands >= PRIME are folded once (x - PRIME) on accept
//   and range_err is raised alongside out_valid for that result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       multiplicand (coefficient), multiplier (twiddle)
//   out_valid  product valid, held until out_ready
//   out_ready  downstream accepts product
//   product    a*b, unsigned, PRODUCT_W bits
//   busy       high whenever the FSM is not in IDLE
//   range_err  (MULT_OPERAND_CHECK_EN only) an operand was >= PRIME
module mod_operand_multiplier
    import ntt_pkg::*;
#(
    parameter int unsigned OPERAND_W = NTT_OPERAND_W,
    parameter int unsigned PRIME     = NTT_PRIME,
    parameter int unsigned PRODUCT_W = ntt_product_w(OPERAND_W),
    parameter int unsigned CNT_W     = $clog2(OPERAND_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] product,
    output logic                 busy
`ifdef MULT_OPERAND_CHECK_EN
    ,
    output logic                 range_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_W - 1);

    mult_state_t          state;
    logic [PRODUCT_W-1:0] acc;
    logic [PRODUCT_W-1:0] a_sh;
    logic [OPERAND_W-1:0] b_sh;
    logic [CNT_W-1:0]     cnt;

    logic [PRODUCT_W-1:0] acc_next;
    logic [OPERAND_W-1:0] a_in;
    logic [OPERAND_W-1:0] b_in;

`ifdef MULT_OPERAND_CHECK_EN
    localparam logic [OPERAND_W:0] PRIME_V = (OPERAND_W + 1)'(PRIME);

    logic a_over;
    logic b_over;
    logic err_flag;

    // Single conditional subtraction; inputs >= 2*PRIME stay out of range
    // but are still flagged.
    always_comb begin
        a_over = {1'b0, a} >= PRIME_V;
        b_over = {1'b0, b} >= PRIME_V;
        a_in   = a_over ? (a - PRIME_V[OPERAND_W-1:0]) : a;
        b_in   = b_over ? (b - PRIME_V[OPERAND_W-1:0]) : b;
    end
`else
    always_comb begin
        a_in = a;
        b_in = b;
    end
`endif

    always_comb begin
        acc_next = acc;
        if (b_sh[0]) begin
            acc_next = acc + a_sh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
`ifdef MULT_OPERAND_CHECK_EN
            err_flag  <= 1'b0;
            range_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= PRODUCT_W'(a_in);
                        b_sh     <= b_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
`ifdef MULT_OPERAND_CHECK_EN
                        err_flag <= a_over || b_over;
`endif
                    end
                end

                MUL: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    // Final iteration: publish the completed sum directly so
                    // product is valid on the same edge out_valid rises.
                    if (cnt == CNT_LAST) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef MULT_OPERAND_CHECK_EN
                        range_err <= err_flag;
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef MULT_OPERAND_CHECK_EN
                        range_err <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : mod_operand_multiplier
